// File: rtl/my_ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : my_ram_loader_if
// Description : Byte-stream handshake plus RAM write bus between an upstream
//               byte source and my_ram_loader. The master side is the byte
//               source / RAM observer; the slave side is the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface my_ram_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [15:0] ram_in;
    logic [13:0] ram_addr;
    logic        ram_load;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, ram_in, ram_addr, ram_load
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, ram_in, ram_addr, ram_load
    );
endinterface
`default_nettype wire

// File: rtl/my_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : my_ram_loader
// Description : Bulk loader for my_ram_16k. Assembles big-endian 16-bit words
//               from a byte stream and writes them to consecutive RAM
//               addresses (wrapping at 2^14) from a programmable base.
//               Optional feature macro: LOADER_CHECKSUM_EN (running 16-bit
//               sum of the words written in the current load).
// Revision    : 1.0 - initial release
// ============================================================================
module my_ram_loader (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic [13:0] base_addr,
    input  wire logic [14:0] word_count,
    my_ram_loader_if.slave   bus,
    output logic             busy,
    output logic             done,
    output logic [15:0]      checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [14:0] MAX_WORDS = 15'd16384;

    state_t      state;
    state_t      state_next;
    logic [15:0] word;
    logic [13:0] addr;
    logic [14:0] remaining;
    logic [14:0] count_sat;

    // Requests beyond the RAM size are clipped to one full pass of the RAM.
    assign count_sat = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next     = state;
        bus.byte_ready = 1'b0;
        bus.ram_load   = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (word_count == 15'd0) ? DONE : HI;
                end
            end
            HI: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    state_next = LO;
                end
            end
            LO: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.ram_load = 1'b1;
                state_next   = (remaining == 15'd1) ? DONE : HI;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word assembly, address and remaining-word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= 16'h0000;
            addr      <= 14'h0000;
            remaining <= 15'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= count_sat;
                    end
                end
                HI: begin
                    if (bus.byte_valid) begin
                        word[15:8] <= bus.byte_data;
                    end
                end
                LO: begin
                    if (bus.byte_valid) begin
                        word[7:0] <= bus.byte_data;
                    end
                end
                WRITE: begin
                    // 14-bit add wraps 3FFF -> 0000 naturally.
                    addr      <= addr + 14'd1;
                    remaining <= remaining - 15'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ram_in   = word;
    assign bus.ram_addr = addr;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;

    // Wraparound sum of words committed in the current load; held until next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 16'h0000;
        end else if (state == IDLE && start) begin
            sum <= 16'h0000;
        end else if (state == WRITE) begin
            sum <= sum + word;
        end
    end

    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_my_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_ram_loader
// Description : Self-checking bench for my_ram_loader: table-driven directed
//               loads, randomized loads against a word-list model, and a
//               hand-written mid-load reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_ram_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] word_count;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int n_checks = 0;
    int n_fails  = 0;

    my_ram_loader_if bus ();

    my_ram_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log of every RAM write {addr, data}: stands in for the RAM contents.
    logic [29:0] wlog[$];
    always @(posedge clk) begin
        if (bus.ram_load) wlog.push_back({bus.ram_addr, bus.ram_in});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: valid always high, 1: valid toggles, 2: random valid.
    // poke: pulse start with a different request while the load is busy.
    task automatic do_load(input string tag, input logic [13:0] base, input logic [14:0] cnt,
                           input logic [7:0] bytes[$], input int mode, input bit poke,
                           input int exp_lat);
        int          idx;
        int          cyc;
        int          lat;
        bit          v;
        logic [15:0] sum;
        logic [15:0] ew;
        logic [13:0] ea;
        idx = 0;
        lat = -1;
        wlog.delete();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        bus.byte_valid = 1'b0;
        cyc = 0;
        while (lat < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 2);
            if (start) begin
                base_addr  = ~base;
                word_count = 15'd5;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            v = v && (idx < bytes.size());
            bus.byte_valid = v;
            bus.byte_data  = v ? bytes[idx] : 8'($urandom);
            #1;
            if (v && bus.byte_ready) idx++;
            if (done) lat = cyc;
        end
        start = 1'b0;
        bus.byte_valid = 1'b0;
        chk({tag, " done seen"}, 32'(lat >= 0), 32'd1);
        if (exp_lat >= 0) chk({tag, " done latency"}, 32'(lat), 32'(exp_lat));
        // Reference: word i is bytes[2i]:bytes[2i+1] at (base+i) mod 2^14.
        sum = 16'h0;
        chk({tag, " write count"}, 32'(wlog.size()), 32'(cnt));
        for (int i = 0; i < int'(cnt) && i < wlog.size(); i++) begin
            ea  = 14'((int'(base) + i) % 16384);
            ew  = {bytes[2*i], bytes[2*i+1]};
            sum = 16'((int'(sum) + int'(ew)) % 65536);
            chk($sformatf("%s write %0d", tag, i), 32'(wlog[i]), 32'({ea, ew}));
        end
        chk({tag, " bytes consumed"}, 32'(idx), 32'(2 * cnt));
        @(negedge clk);
        #1;
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " idle not busy"}, 32'(busy), 32'd0);
        chk({tag, " final addr"}, 32'(bus.ram_addr), 32'((int'(base) + int'(cnt)) % 16384));
`ifdef LOADER_CHECKSUM_EN
        chk({tag, " checksum"}, 32'(checksum), 32'(sum));
`else
        chk({tag, " checksum"}, 32'(checksum), 32'h0);
`endif
    endtask

    typedef struct {
        string       tag;
        logic [13:0] base;
        logic [14:0] cnt;
        logic [7:0]  b0, b1, b2, b3;
        int          mode;
        bit          poke;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] q[$];
        int         tmo;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        vecs[0] = '{"basic",   14'h0000, 15'd2, 8'h00, 8'h02, 8'h00, 8'h09, 0, 1'b0, 7};
        vecs[1] = '{"wrap",    14'h3FFF, 15'd2, 8'h00, 8'h01, 8'h12, 8'h34, 0, 1'b0, 7};
        vecs[2] = '{"backpr",  14'h21A7, 15'd1, 8'hAB, 8'hCD, 8'h00, 8'h00, 1, 1'b0, -1};
        vecs[3] = '{"zero",    14'h0123, 15'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1};
        vecs[4] = '{"ignstart",14'h0040, 15'd2, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 0, 1'b1, 7};
        vecs[5] = '{"cksum",   14'h1000, 15'd2, 8'hFF, 8'hFF, 8'h00, 8'h02, 0, 1'b0, 7};

        #3;
        #1;
        chk("reset ready", 32'(bus.byte_ready), 32'd0);
        chk("reset load",  32'(bus.ram_load), 32'd0);
        chk("reset addr",  32'(bus.ram_addr), 32'd0);
        chk("reset in",    32'(bus.ram_in), 32'd0);
        chk("reset busy",  32'(busy), 32'd0);
        chk("reset done",  32'(done), 32'd0);
        chk("reset cksum", 32'(checksum), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            q = '{vecs[k].b0, vecs[k].b1, vecs[k].b2, vecs[k].b3};
            while (q.size() > 2 * vecs[k].cnt) void'(q.pop_back());
            do_load(vecs[k].tag, vecs[k].base, vecs[k].cnt, q, vecs[k].mode,
                    vecs[k].poke, vecs[k].lat);
        end

`ifdef LOADER_CHECKSUM_EN
        chk("cksum FFFF+0002", 32'(checksum), 32'h0001);
`endif

        for (int r = 0; r < 8; r++) begin
            logic [14:0] n;
            int          md;
            n  = 15'($urandom_range(1, 6));
            md = (r % 2 == 0) ? 0 : 2;
            q.delete();
            for (int j = 0; j < 2 * int'(n); j++) q.push_back(8'($urandom));
            do_load($sformatf("rand%0d", r), 14'($urandom), n, q, md, 1'b0,
                    (md == 0) ? 3 * int'(n) + 1 : -1);
        end

        // Reset mid-load after the first word has been written.
        wlog.delete();
        @(negedge clk);
        start = 1'b1;
        base_addr = 14'h0100;
        word_count = 15'd3;
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h11;
        tmo = 0;
        while (wlog.size() == 0 && tmo < 20) begin
            @(posedge clk);
            #1;
            if (bus.byte_data == 8'h11 && dut.bus.byte_ready) bus.byte_data = 8'h22;
            tmo++;
        end
        chk("rst first word written", 32'(wlog.size()), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst ready", 32'(bus.byte_ready), 32'd0);
        chk("rst load",  32'(bus.ram_load), 32'd0);
        chk("rst addr",  32'(bus.ram_addr), 32'd0);
        chk("rst in",    32'(bus.ram_in), 32'd0);
        chk("rst busy",  32'(busy), 32'd0);
        chk("rst done",  32'(done), 32'd0);
        chk("rst cksum", 32'(checksum), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.byte_valid = 1'b0;
        #1;
        chk("rst no further writes", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("rst kept word", 32'(wlog[0]), 32'({14'h0100, 16'h1122}));
        chk("rst idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
